// File: rtl/instr_queue_pkg.sv
// Shared widths, constants and entry type for the instruction queue slice.
// IqDepth/IqAddrWidth size the queue instantiated at the top level.
package instr_queue_pkg;

  localparam int PcLength    = 31;
  localparam int InstrLength = 31;
  localparam int IqDepth     = 16;
  localparam int IqAddrWidth = 4;

  localparam logic [31:0] Zero  = 32'h0000_0000;
  localparam logic        True  = 1'b1;
  localparam logic        False = 1'b0;

  typedef logic [PcLength:0]    pc_t;
  typedef logic [InstrLength:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } iq_entry_t;

  localparam iq_entry_t EmptyEntry = '{pc: Zero, instr: Zero};

endpackage

// File: rtl/instr_queue_if.sv
// Fetcher/dispatch-side bundle for the instruction queue.
// The master drives push data, stall and control; the queue is the slave.
interface instr_queue_if;
  import instr_queue_pkg::*;

  logic   rdy;
  logic   clr;
  logic   is_valid_from_fetcher;
  pc_t    pc_from_fetcher;
  instr_t instr_from_fetcher;
  logic   is_full_to_fetcher;
  logic   is_stall_from_dispatch;
  logic   is_empty_to_dc;
  pc_t    pc_to_dc;
  instr_t instr_to_dc;

  modport master (
    output rdy, clr, is_valid_from_fetcher, pc_from_fetcher, instr_from_fetcher,
           is_stall_from_dispatch,
    input  is_full_to_fetcher, is_empty_to_dc, pc_to_dc, instr_to_dc
  );

  modport slave (
    input  rdy, clr, is_valid_from_fetcher, pc_from_fetcher, instr_from_fetcher,
           is_stall_from_dispatch,
    output is_full_to_fetcher, is_empty_to_dc, pc_to_dc, instr_to_dc
  );

endinterface

// File: rtl/instr_queue.sv
// Show-ahead FIFO of (pc, instr) pairs between fetcher and decoder.
// Head entry is presented combinationally; clr empties the queue in one cycle.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int Depth     = IqDepth,
  parameter int AddrWidth = IqAddrWidth
) (
  input logic          clk,
  input logic          rst,
  instr_queue_if.slave iq
);

  localparam logic [AddrWidth:0]   CountZero = {(AddrWidth+1){1'b0}};
  localparam logic [AddrWidth:0]   CountOne  = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth:0]   CountFull = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth-1:0] PtrZero   = {AddrWidth{1'b0}};
  localparam logic [AddrWidth-1:0] PtrOne    = {{(AddrWidth-1){1'b0}}, 1'b1};

  iq_entry_t            mem_r [Depth];
  logic [AddrWidth-1:0] head_r;
  logic [AddrWidth-1:0] tail_r;
  logic [AddrWidth:0]   count_r;

  logic      empty_s;
  logic      full_s;
  logic      push_s;
  logic      pop_s;
  iq_entry_t head_entry_s;

  // Occupancy flags and the push/pop qualifiers
  always_comb begin
    empty_s = (count_r == CountZero);
    full_s  = (count_r == CountFull);
    push_s  = rst & iq.is_valid_from_fetcher & ~full_s & iq.rdy & ~iq.clr;
    pop_s   = rst & ~empty_s & ~iq.is_stall_from_dispatch & iq.rdy & ~iq.clr;
  end

  // Pointer and occupancy state; clr outranks the rdy freeze
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= PtrZero;
      tail_r  <= PtrZero;
      count_r <= CountZero;
    end else if (iq.clr) begin
      head_r  <= PtrZero;
      tail_r  <= PtrZero;
      count_r <= CountZero;
    end else if (iq.rdy) begin
      if (push_s) begin
        tail_r <= tail_r + PtrOne;
      end
      if (pop_s) begin
        head_r <= head_r + PtrOne;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CountOne;
        2'b01:   count_r <= count_r - CountOne;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents survive reset and flush, only pointers move
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= '{pc: iq.pc_from_fetcher, instr: iq.instr_from_fetcher};
    end
  end

  // Show-ahead head presentation, forced to zero when nothing is resident
  always_comb begin
    head_entry_s = EmptyEntry;
    if (empty_s) begin
      head_entry_s = EmptyEntry;
    end else begin
      head_entry_s = mem_r[head_r];
    end
  end

  // Drive the bundle outputs
  always_comb begin
    iq.is_empty_to_dc     = empty_s;
    iq.is_full_to_fetcher = full_s;
    iq.pc_to_dc           = head_entry_s.pc;
    iq.instr_to_dc        = head_entry_s.instr;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: reset, push/pop, fill/overflow,
// wrap streaming, flush, rdy freeze and asynchronous mid-cycle reset.
module tb_instr_queue;
  import instr_queue_pkg::*;

  logic clk;
  logic rst;
  int   checks_cnt;
  int   fail_cnt;

  instr_queue_if iq_bus ();

  instr_queue #(
    .Depth     (IqDepth),
    .AddrWidth (IqAddrWidth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic valid, input logic [31:0] pc, input logic [31:0] instr);
    iq_bus.is_valid_from_fetcher = valid;
    iq_bus.pc_from_fetcher       = pc;
    iq_bus.instr_from_fetcher    = instr;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_empty"}, 64'(iq_bus.is_empty_to_dc), 64'd1);
    check_val({tag, "_full"},  64'(iq_bus.is_full_to_fetcher), 64'd0);
    check_val({tag, "_pc"},    64'(iq_bus.pc_to_dc), 64'd0);
    check_val({tag, "_instr"}, 64'(iq_bus.instr_to_dc), 64'd0);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b0;
    iq_bus.rdy = 1'b1;
    iq_bus.clr = 1'b0;
    iq_bus.is_stall_from_dispatch = 1'b0;
    set_push(1'b0, 32'h0, 32'h0);

    // Reset then idle
    tick();
    tick();
    check_idle("rst_hold");
    rst = 1'b1;
    tick();
    check_idle("rst_idle");

    // Single push and pop
    set_push(1'b1, 32'h0000_0100, 32'h0050_0093);
    tick();
    set_push(1'b0, 32'h0, 32'h0);
    check_val("single_empty", 64'(iq_bus.is_empty_to_dc), 64'd0);
    check_val("single_pc",    64'(iq_bus.pc_to_dc), 64'h100);
    check_val("single_instr", 64'(iq_bus.instr_to_dc), 64'h0050_0093);
    tick();
    check_idle("single_drained");

    // Fill with stall high, then overflow attempt
    iq_bus.is_stall_from_dispatch = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_push(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i));
      tick();
      if (i == 14) check_val("fill_not_full_15", 64'(iq_bus.is_full_to_fetcher), 64'd0);
      if (i == 15) check_val("fill_full_16", 64'(iq_bus.is_full_to_fetcher), 64'd1);
    end
    set_push(1'b0, 32'h0, 32'h0);
    check_val("fill_full_after_17", 64'(iq_bus.is_full_to_fetcher), 64'd1);
    check_val("fill_head_pc", 64'(iq_bus.pc_to_dc), 64'h0);
    iq_bus.is_stall_from_dispatch = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_val("drain_pc",    64'(iq_bus.pc_to_dc), 64'(i * 4));
      check_val("drain_instr", 64'(iq_bus.instr_to_dc), 64'(32'hA000_0000 + 32'(i)));
      tick();
      if (i == 0) check_val("drain_full_falls", 64'(iq_bus.is_full_to_fetcher), 64'd0);
    end
    check_idle("drain_done");

    // Streaming across the pointer wrap, one in and one out per cycle
    set_push(1'b1, 32'h0000_8000, 32'hB000_0000);
    tick();
    for (int i = 1; i < 40; i++) begin
      set_push(1'b1, 32'h0000_8000 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      check_val("wrap_pc",    64'(iq_bus.pc_to_dc), 64'(32'h0000_8000 + 32'((i - 1) * 4)));
      check_val("wrap_instr", 64'(iq_bus.instr_to_dc), 64'(32'hB000_0000 + 32'(i - 1)));
      check_val("wrap_empty", 64'(iq_bus.is_empty_to_dc), 64'd0);
      tick();
    end
    set_push(1'b0, 32'h0, 32'h0);
    check_val("wrap_last_pc", 64'(iq_bus.pc_to_dc), 64'(32'h0000_8000 + 32'(39 * 4)));
    tick();
    check_idle("wrap_done");

    // Flush with a simultaneous push
    iq_bus.is_stall_from_dispatch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, 32'h0000_1000 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      tick();
    end
    check_val("flush_pre_pc", 64'(iq_bus.pc_to_dc), 64'h1000);
    iq_bus.clr = 1'b1;
    set_push(1'b1, 32'h0000_0200, 32'hC000_0200);
    tick();
    iq_bus.clr = 1'b0;
    set_push(1'b0, 32'h0, 32'h0);
    check_idle("flush_after");
    set_push(1'b1, 32'h0000_0300, 32'hC000_0300);
    tick();
    set_push(1'b0, 32'h0, 32'h0);
    check_val("flush_next_pc",    64'(iq_bus.pc_to_dc), 64'h300);
    check_val("flush_next_instr", 64'(iq_bus.instr_to_dc), 64'hC000_0300);
    iq_bus.is_stall_from_dispatch = 1'b0;
    tick();
    check_idle("flush_popped");

    // rdy low freezes pointers, count and memory
    iq_bus.is_stall_from_dispatch = 1'b1;
    set_push(1'b1, 32'h0000_0500, 32'hD000_0500);
    tick();
    set_push(1'b1, 32'h0000_0504, 32'hD000_0504);
    tick();
    iq_bus.rdy = 1'b0;
    iq_bus.is_stall_from_dispatch = 1'b0;
    set_push(1'b1, 32'h0000_0600, 32'hD000_0600);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("freeze_pc",    64'(iq_bus.pc_to_dc), 64'h500);
      check_val("freeze_empty", 64'(iq_bus.is_empty_to_dc), 64'd0);
    end
    iq_bus.rdy = 1'b1;
    set_push(1'b0, 32'h0, 32'h0);
    tick();
    check_val("freeze_second_pc", 64'(iq_bus.pc_to_dc), 64'h504);
    tick();
    check_idle("freeze_count_kept");

    // Asynchronous reset mid-cycle with three entries resident
    iq_bus.is_stall_from_dispatch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h0000_0700 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      tick();
    end
    set_push(1'b0, 32'h0, 32'h0);
    check_val("areset_pre_pc", 64'(iq_bus.pc_to_dc), 64'h700);
    #2;
    rst = 1'b0;
    #1;
    check_idle("areset_now");
    tick();
    rst = 1'b1;
    tick();
    check_idle("areset_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
